// File: rtl/task_8_in_arb.sv
// Frame-level round-robin arbiter sharing one task input stage between NUM_SRC stream sources.
// A source keeps the grant through its last beat and until the task reports completion.
module task_8_in_arb #(
    parameter int NUM_SRC         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_FRAME_WORDS = 243,
    parameter int TIMEOUT_CYCLES  = 4096,
    localparam int GW = $clog2(NUM_SRC)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]            i_src_last,
    output logic [NUM_SRC-1:0]            o_src_ready,
    output logic                          o_tdata_valid,
    output logic [DATA_WIDTH-1:0]         o_tdata,
    output logic                          o_tdata_last,
    input  logic                          i_tready,
    input  logic                          i_output_last,
    output logic [GW-1:0]                 o_grant_id,
    output logic                          o_busy,
    output logic                          o_err_overlen,
    output logic                          o_err_timeout,
    output logic [2:0]                    o_dbg_state
);

    localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        STREAM    = 3'd2,
        DRAIN     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   word_cnt;
    logic [TW-1:0]   to_cnt;
    logic [GW-1:0]   arb_sel;
    logic            arb_found;
    int              arb_idx;
    logic            g_valid;
    logic            g_last;
    logic            forced_last;
    logic            xfer;

    assign g_valid     = i_src_valid[o_grant_id];
    assign g_last      = i_src_last[o_grant_id];
    assign forced_last = (word_cnt == CW'(MAX_FRAME_WORDS - 1));
    assign xfer        = g_valid && i_tready;
    assign o_busy      = (state != IDLE);
    assign o_dbg_state = state;

    // Search starts just after the last served source, so it becomes lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            arb_idx = (int'(last_grant) + i) % NUM_SRC;
            if (!arb_found && i_src_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = GW'(arb_idx);
            end
        end
    end

    always_comb begin
        o_src_ready   = '0;
        o_tdata_valid = 1'b0;
        o_tdata       = '0;
        o_tdata_last  = 1'b0;
        case (state)
            STREAM: begin
                o_src_ready[o_grant_id] = i_tready;
                o_tdata_valid           = g_valid;
                o_tdata                 = i_src_data[o_grant_id*DATA_WIDTH +: DATA_WIDTH];
                o_tdata_last            = g_last | forced_last;
            end
            DRAIN: o_src_ready[o_grant_id] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_grant_id    <= '0;
            last_grant    <= GW'(NUM_SRC - 1);
            word_cnt      <= '0;
            to_cnt        <= '0;
            o_err_overlen <= 1'b0;
            o_err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_src_valid) state <= ARB;
                end
                ARB: begin
                    if (arb_found) begin
                        o_grant_id <= arb_sel;
                        word_cnt   <= '0;
                        state      <= STREAM;
                    end else begin
                        state <= IDLE;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + CW'(1);
                        if (g_last) begin
                            to_cnt <= '0;
                            state  <= WAIT_DONE;
                        end else if (forced_last) begin
                            o_err_overlen <= 1'b1;
                            state         <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (g_valid && g_last) begin
                        to_cnt <= '0;
                        state  <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_output_last || (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
                        if (!i_output_last) o_err_timeout <= 1'b1;
                        last_grant <= o_grant_id;
                        to_cnt     <= '0;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_task_8_in_arb.sv
// Directed bench for task_8_in_arb: a default-length instance plus a MAX_FRAME_WORDS=4 instance
// for truncation; both use a 16-cycle completion timeout.
module tb_task_8_in_arb;

    localparam int NS = 4;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS-1:0]    src_valid;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_last;
    logic [NS-1:0]    src_ready;
    logic             tvalid;
    logic [DW-1:0]    tdata;
    logic             tlast;
    logic             tready;
    logic             output_last;
    logic [1:0]       grant_id;
    logic             busy;
    logic             err_overlen;
    logic             err_timeout;
    logic [2:0]       dbg_state;

    logic [NS-1:0]    ov_valid;
    logic [NS*DW-1:0] ov_data;
    logic [NS-1:0]    ov_last;
    logic [NS-1:0]    ov_src_ready;
    logic             ov_tvalid;
    logic [DW-1:0]    ov_tdata;
    logic             ov_tlast;
    logic [1:0]       ov_grant;
    logic             ov_busy;
    logic             ov_err_overlen;
    logic             ov_err_timeout;
    logic [2:0]       ov_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    task_8_in_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_FRAME_WORDS(243), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_src_valid(src_valid), .i_src_data(src_data),
        .i_src_last(src_last), .o_src_ready(src_ready), .o_tdata_valid(tvalid), .o_tdata(tdata),
        .o_tdata_last(tlast), .i_tready(tready), .i_output_last(output_last), .o_grant_id(grant_id),
        .o_busy(busy), .o_err_overlen(err_overlen), .o_err_timeout(err_timeout), .o_dbg_state(dbg_state)
    );

    task_8_in_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_FRAME_WORDS(4), .TIMEOUT_CYCLES(16)) dut_ov (
        .i_clk(clk), .i_rst_n(rst_n), .i_src_valid(ov_valid), .i_src_data(ov_data),
        .i_src_last(ov_last), .o_src_ready(ov_src_ready), .o_tdata_valid(ov_tvalid), .o_tdata(ov_tdata),
        .o_tdata_last(ov_tlast), .i_tready(tready), .i_output_last(output_last), .o_grant_id(ov_grant),
        .o_busy(ov_busy), .o_err_overlen(ov_err_overlen), .o_err_timeout(ov_err_timeout), .o_dbg_state(ov_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Granted source g presents word w of an n-word frame; others hold their first word.
    task automatic drive_data(input int g, input int w, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < NS; k++) begin
            src_data[k*DW +: DW] = (k == g) ? base + DW'(w) : DW'(8'hE0 + k);
            src_last[k]          = (k == g) && (w == n - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; src_valid = '0; src_last = '0; output_last = 1'b0; tready = 1'b0;
        ov_valid = '0; ov_last = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requests with mask req, expects grant g, streams n words at full rate, then
    // pulses output_last on the gap-th WAIT_DONE cycle (gap = 0 leaves it in WAIT_DONE).
    task automatic run_frame(input int g, input int n, input logic [NS-1:0] req,
                             input logic [NS-1:0] post, input int gap, input logic [DW-1:0] base);
        @(negedge clk);
        src_valid = req; output_last = 1'b0; tready = 1'b1;
        drive_data(g, 0, n, base);
        #1 chk("idle_state", dbg_state, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        #1 chk("arb_state", dbg_state, 1);
        chk("arb_tvalid", tvalid, 0);
        chk("arb_ready", src_ready, 0);
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            drive_data(g, w, n, base);
            #1 chk("grant_id", grant_id, g);
            chk("beat_valid", tvalid, 1);
            chk("beat_data", tdata, base + DW'(w));
            chk("beat_last", tlast, (w == n - 1));
            chk("beat_ready", src_ready, 4'(1) << g);
        end
        for (int d = 1; d <= gap; d++) begin
            @(negedge clk);
            if (d == 1) src_valid = post;
            if (d == gap) output_last = 1'b1;
            #1 chk("wait_state", dbg_state, 4);
            chk("wait_ready", src_ready, 0);
            chk("wait_tvalid", tvalid, 0);
        end
        if (gap > 0) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        int w;
        int c;
        rst_n = 1'b0; src_valid = '0; src_data = '0; src_last = '0; tready = 1'b0;
        output_last = 1'b0; ov_valid = '0; ov_data = '0; ov_last = '0;

        // Reset values
        @(negedge clk);
        #1 chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_ovl", err_overlen, 0);
        chk("rst_err_to", err_timeout, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_ov_busy", ov_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single source 2, 5 words 0x10..0x14, done 3 cycles after last
        run_frame(2, 5, 4'b0100, 4'b0000, 3, 8'h10);
        @(negedge clk);
        output_last = 1'b0;
        #1 chk("t1_busy_drop", busy, 0);
        chk("t1_grant_hold", grant_id, 2);

        // All sources requesting: rotation 0,1,2,3,0
        do_reset();
        run_frame(0, 3, 4'hF, 4'hF, 1, 8'h40);
        run_frame(1, 3, 4'hF, 4'hF, 1, 8'h50);
        run_frame(2, 3, 4'hF, 4'hF, 1, 8'h60);
        run_frame(3, 3, 4'hF, 4'hF, 1, 8'h70);
        run_frame(0, 3, 4'hF, 4'hF, 1, 8'h80);
        @(negedge clk);
        src_valid = '0; output_last = 1'b0;

        // Backpressure on source 1, 6-word frame, tready 1,0,0,1,...
        pat = 4'b1001;
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h30 + DW'(i));
        @(negedge clk);
        src_valid = 4'b0010; tready = 1'b1; drive_data(1, 0, 6, 8'h30);
        @(negedge clk);
        w = 0; c = 0;
        while (w < 6 && c < 40) begin
            @(negedge clk);
            tready = pat[c % 4];
            drive_data(1, w, 6, 8'h30);
            #1 chk("bp_grant", grant_id, 1);
            chk("bp_valid", tvalid, 1);
            chk("bp_data", tdata, exp_q[0]);
            chk("bp_last", tlast, (w == 5));
            chk("bp_ready", src_ready, tready ? 4'b0010 : 4'b0000);
            if (tready) begin
                void'(exp_q.pop_front());
                w++;
            end
            c++;
        end
        chk("bp_words", w, 6);
        @(negedge clk);
        src_valid = '0; tready = 1'b1; output_last = 1'b1;
        #1 chk("bp_wait_state", dbg_state, 4);
        @(negedge clk);
        output_last = 1'b0;
        #1 chk("bp_idle", dbg_state, 0);

        // Overlength on the MAX_FRAME_WORDS=4 instance: 7 words, last on the 7th
        @(negedge clk);
        ov_valid = 4'b1000; tready = 1'b1; ov_data[3*DW +: DW] = 8'h50; ov_last = '0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ov_data[3*DW +: DW] = 8'h50 + DW'(i);
            ov_last[3] = (i == 6);
            #1 chk("ov_ready", ov_src_ready, 4'b1000);
            if (i < 4) begin
                chk("ov_state_stream", ov_state, 2);
                chk("ov_valid", ov_tvalid, 1);
                chk("ov_data", ov_tdata, 8'h50 + DW'(i));
                chk("ov_last", ov_tlast, (i == 3));
                chk("ov_err_early", ov_err_overlen, 0);
            end else begin
                chk("ov_state_drain", ov_state, 3);
                chk("ov_drop_valid", ov_tvalid, 0);
                chk("ov_err_set", ov_err_overlen, 1);
            end
        end
        @(negedge clk);
        ov_valid = '0; ov_last = '0; output_last = 1'b1;
        #1 chk("ov_wait_state", ov_state, 4);
        chk("ov_grant", ov_grant, 3);
        chk("ov_err_sticky", ov_err_overlen, 1);
        chk("main_no_ovl", err_overlen, 0);
        @(negedge clk);
        output_last = 1'b0;
        #1 chk("ov_idle", ov_state, 0);

        // Timeout: 1-word frame from source 1, output_last withheld
        run_frame(1, 1, 4'b0010, 4'b0000, 0, 8'hA0);
        for (int d = 1; d <= 16; d++) begin
            @(negedge clk);
            if (d == 1) src_valid = '0;
            #1 if (d == 1 || d == 16) begin
                chk("to_wait_state", dbg_state, 4);
                chk("to_err_pending", err_timeout, 0);
            end
        end
        @(negedge clk);
        #1 chk("to_idle", dbg_state, 0);
        chk("to_err_set", err_timeout, 1);
        run_frame(2, 2, 4'b0110, 4'b0000, 1, 8'hB0);
        @(negedge clk);
        output_last = 1'b0;
        #1 chk("to_err_sticky", err_timeout, 1);

        // Async reset during word 2 of a 5-word frame from source 0
        @(negedge clk);
        src_valid = 4'b0001; tready = 1'b1; drive_data(0, 0, 5, 8'hC0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_data(0, i, 5, 8'hC0);
        end
        #1 chk("ar_pre_valid", tvalid, 1);
        #2 rst_n = 1'b0;
        #1 chk("ar_tvalid", tvalid, 0);
        chk("ar_tdata", tdata, 0);
        chk("ar_tlast", tlast, 0);
        chk("ar_ready", src_ready, 0);
        chk("ar_busy", busy, 0);
        chk("ar_grant", grant_id, 0);
        chk("ar_err_to", err_timeout, 0);
        src_valid = '0; src_last = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 2, 4'b1010, 4'b1000, 1, 8'hD0);
        @(negedge clk);
        src_valid = '0; output_last = 1'b0;
        #1 chk("ar_end_idle", dbg_state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/task_8_in_arb.md
Name: task_8_in_arb

Overview:
- Frame-level round-robin arbiter that shares a single task input stage between NUM_SRC stream sources.
- Grants one source for a whole frame (through its last beat) and forwards that frame to the input stage.
- Holds the grant until the downstream task signals completion with i_output_last, then rotates priority.
- Enforces a maximum frame length and a completion timeout, both reported as sticky error flags.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- DATA_WIDTH, 8, stream word width.
- MAX_FRAME_WORDS, 243, maximum words per frame; longer frames are truncated.
- TIMEOUT_CYCLES, 4096, maximum WAIT_DONE cycles before abort.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_src_valid  in  NUM_SRC  per-source data valid.
- i_src_data  in  NUM_SRC*DATA_WIDTH  per-source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_src_last  in  NUM_SRC  per-source last-beat flag.
- o_src_ready  out  NUM_SRC  per-source ready.
- o_tdata_valid  out  1  valid to the input stage.
- o_tdata  out  DATA_WIDTH  data to the input stage.
- o_tdata_last  out  1  last beat to the input stage.
- i_tready  in  1  ready from the input stage.
- i_output_last  in  1  one-cycle pulse: downstream task finished the frame.
- o_grant_id  out  $clog2(NUM_SRC)  currently/last granted source.
- o_busy  out  1  high in every state except IDLE.
- o_err_overlen  out  1  sticky: a frame exceeded MAX_FRAME_WORDS.
- o_err_timeout  out  1  sticky: WAIT_DONE timed out.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs = 0; o_src_ready = 0.
  - Round-robin pointer last_grant = NUM_SRC-1, so source 0 has first priority.
  - Word counter = 0; error flags = 0.
- Reset mid-frame aborts immediately; no partial beat or last is emitted after release.
- States: IDLE, ARB, STREAM, DRAIN, WAIT_DONE.
- IDLE: if any i_src_valid, go to ARB next cycle.
- ARB (exactly 1 cycle):
  - Select the first requesting source searching from last_grant+1 upward, wrapping modulo NUM_SRC.
  - Register the selection into o_grant_id; clear the word counter; go to STREAM.
  - If no source is valid in this cycle (request withdrawn), return to IDLE.
- STREAM: combinational pass-through, zero latency.
  - Let g = o_grant_id.
  - o_tdata_valid = i_src_valid[g].
  - o_tdata = i_src_data[g].
  - o_src_ready[g] = i_tready; all other o_src_ready bits = 0.
  - A beat transfers when i_src_valid[g] && i_tready; each beat increments the counter.
  - o_tdata_last = i_src_last[g] OR (counter == MAX_FRAME_WORDS-1).
  - Transfer with i_src_last[g] -> WAIT_DONE.
  - Transfer on forced last without i_src_last[g]:
    - Set o_err_overlen.
    - If i_src_last[g] has not yet been seen, go to DRAIN.
- DRAIN:
  - o_src_ready[g] = 1; o_tdata_valid = 0.
  - Source g's words are discarded until a beat with i_src_last[g], then go to WAIT_DONE.
- WAIT_DONE:
  - All ready = 0, o_tdata_valid = 0.
  - Timeout counter increments each cycle.
  - i_output_last -> IDLE; last_grant <= g; timeout counter cleared.
  - Counter reaching TIMEOUT_CYCLES-1 without i_output_last:
    - Set o_err_timeout; go to IDLE; last_grant <= g.
- i_output_last outside WAIT_DONE is ignored.
- Simultaneous final beat and i_output_last: the beat is handled; the pulse is ignored, since the state is not yet WAIT_DONE.
- Priority: a source that was just served is lowest priority next round. No source waits more than NUM_SRC-1 frames.
- Error flags clear only on reset.

Test Plan:
- Single source 2, 5-word frame 0x10..0x14, i_tready = 1, i_output_last 3 cycles after last:
  - Output words match with last on 0x14.
  - o_grant_id = 2; o_busy deasserts the cycle after i_output_last.
- All 4 sources valid continuously, each 3-word frames, output_last after each:
  - Grant order 0, 1, 2, 3, 0.
  - No ready to non-granted sources, ever.
- Backpressure: i_tready toggling 1,0,0,1… during a 6-word frame:
  - No duplicated or dropped words.
  - o_src_ready[g] mirrors i_tready.
- Overlength: MAX_FRAME_WORDS = 4, source sends 7 words with last on the 7th:
  - o_tdata_last on word 4; words 5–7 consumed but not forwarded.
  - o_err_overlen = 1; state reaches WAIT_DONE.
- Timeout: TIMEOUT_CYCLES = 16, i_output_last withheld after a frame:
  - o_err_timeout = 1 after 16 WAIT_DONE cycles; returns to IDLE.
  - Next grant goes to the following requester.
- Async reset asserted mid-STREAM (word 2 of 5):
  - All outputs 0 immediately.
  - After release, a new request from source 1 is granted before source 0 (pointer reset; source 0 not requesting).
